// File: rtl/bitmap_packer_pkg.sv
// Shared constants and FSM state type for the bitmap packer.
// PACKER_ZERO_SKIP_EN (optional) enables the zero-width element class.
package bt_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_8    = 2'b01;
    localparam logic [1:0] CODE_16   = 2'b10;
    localparam logic [1:0] CODE_32   = 2'b11;

    localparam logic [5:0] W_ZERO = 6'd0;
    localparam logic [5:0] W_8    = 6'd8;
    localparam logic [5:0] W_16   = 6'd16;
    localparam logic [5:0] W_32   = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/bitmap_packer_if.sv
// Valid/ready stream bundle used on both sides of the bitmap packer.
// "last" is only meaningful on the output stream.
interface bitmap_packer_if #(parameter int W = 32) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bitmap_packer_classify.sv
// Classifies one 32-bit element into a 2-bit width code and its bit width.
// With PACKER_ZERO_SKIP_EN undefined, zero is carried as a single 0x00 byte.
module bitmap_classify
    import bt_pkg::*;
(
    input  logic [31:0] value,
    output logic [1:0]  code,
    output logic [5:0]  width
);

    always_comb begin
        code  = CODE_32;
        width = W_32;
`ifdef PACKER_ZERO_SKIP_EN
        if (value == 32'd0) begin
            code  = CODE_ZERO;
            width = W_ZERO;
        end else if (value[31:8] == 24'd0) begin
            code  = CODE_8;
            width = W_8;
        end else if (value[31:16] == 16'd0) begin
            code  = CODE_16;
            width = W_16;
        end
`else
        if (value[31:8] == 24'd0) begin
            code  = CODE_8;
            width = W_8;
        end else if (value[31:16] == 16'd0) begin
            code  = CODE_16;
            width = W_16;
        end
`endif
    end

endmodule

// File: rtl/bitmap_packer.sv
// Packs eight 32-bit elements into a header word plus variable-width payload.
// Optional macro: PACKER_ZERO_SKIP_EN (zero elements take no payload bits).
//
//   state      | meaning
//   ST_IDLE    | s_ready high, waiting for a block
//   ST_HEADER  | presenting {6'b0, total_bits, bitmap}
//   ST_PAYLOAD | presenting payload word idx of ceil(total_bits/32)
module bitmap_packer
    import bt_pkg::*;
(
    input  logic            aclk,
    input  logic            areset,
    bitmap_packer_if.slave  s,
    bitmap_packer_if.master m
);

    logic [1:0]   code  [8];
    logic [5:0]   width [8];
    logic [9:0]   offs  [9];
    logic [31:0]  elem;
    logic [31:0]  masked;
    logic [255:0] packed_c;
    logic [15:0]  bitmap_c;

    state_t       state, state_n;
    logic [2:0]   idx, idx_n;
    logic [15:0]  bitmap_q;
    logic [9:0]   total_q;
    logic [255:0] buf_q;
    logic [3:0]   n_words;
    logic         last_word;
    logic         accept;

    for (genvar gi = 0; gi < 8; gi++) begin : g_cls
        bitmap_classify u_cls (
            .value (s.data[32*gi +: 32]),
            .code  (code[gi]),
            .width (width[gi])
        );
    end

    // Each element lands at the running sum of the widths before it.
    always_comb begin
        packed_c = '0;
        bitmap_c = '0;
        elem     = '0;
        masked   = '0;
        offs[0]  = '0;
        for (int i = 0; i < 8; i++) begin
            elem = s.data[32*i +: 32];
            case (code[i])
                CODE_8:  masked = {24'd0, elem[7:0]};
                CODE_16: masked = {16'd0, elem[15:0]};
                CODE_32: masked = elem;
                default: masked = '0;
            endcase
            packed_c = packed_c | ({224'd0, masked} << offs[i]);
            offs[i+1] = offs[i] + {4'd0, width[i]};
            bitmap_c[2*i +: 2] = code[i];
        end
    end

    assign n_words   = total_q[8:5] + {3'd0, (total_q[9] | (|total_q[4:0]))};
    assign last_word = ({1'b0, idx} == (n_words - 4'd1));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            bitmap_q <= '0;
            total_q  <= '0;
            buf_q    <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                bitmap_q <= bitmap_c;
                total_q  <= offs[8];
                buf_q    <= packed_c;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        accept  = 1'b0;
        s.ready = 1'b0;
        m.valid = 1'b0;
        m.data  = '0;
        m.last  = 1'b0;
        case (state)
            ST_IDLE: begin
                s.ready = 1'b1;
                if (s.valid) begin
                    accept  = 1'b1;
                    idx_n   = '0;
                    state_n = ST_HEADER;
                end
            end
            ST_HEADER: begin
                m.valid = 1'b1;
                m.data  = {6'd0, total_q, bitmap_q};
                m.last  = (total_q == 10'd0);
                if (m.ready)
                    state_n = (total_q == 10'd0) ? ST_IDLE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m.valid = 1'b1;
                m.data  = buf_q[{idx, 5'd0} +: 32];
                m.last  = last_word;
                if (m.ready) begin
                    if (last_word) begin
                        idx_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bitmap_packer.sv
// Scoreboard bench for bitmap_packer: directed blocks, stall and reset cases.
module tb_bitmap_packer;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    bitmap_packer_if #(.W(256)) s_if ();
    bitmap_packer_if #(.W(32))  m_if ();

    bitmap_packer dut (
        .aclk   (aclk),
        .areset (areset),
        .s      (s_if),
        .m      (m_if)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   mon_words = 0;
    int   rdy_mode = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    function automatic logic [255:0] blk8(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge aclk) begin
        exp_t e;
        if (!areset) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, m_if.valid}, 32'd1);
                check("hold_data", m_if.data, prev_data);
                check("hold_last", {31'd0, m_if.last}, {31'd0, prev_last});
            end
            if (m_if.valid) check("s_ready_busy", {31'd0, s_if.ready}, 32'd0);
            if (m_if.valid && m_if.ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got 0x%08h expected no word", m_if.data);
                end else begin
                    e = sb.pop_front();
                    check("word_data", m_if.data, e.data);
                    check("word_last", {31'd0, m_if.last}, {31'd0, e.last});
                end
                mon_words++;
            end
            prev_stall <= m_if.valid && !m_if.ready;
            prev_data  <= m_if.data;
            prev_last  <= m_if.last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_if.ready = 1'b1;
                1:       m_if.ready = ~m_if.ready;
                default: m_if.ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [255:0] blk);
        int t;
        t = 0;
        @(posedge aclk);
        #1;
        s_if.data  = blk;
        s_if.valid = 1'b1;
        @(negedge aclk);
        while (!s_if.ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        if (!s_if.ready) begin
            n_total++;
            $display("FAIL accept_timeout: s_ready=0 after %0d cycles, required 1", t);
            s_if.valid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        s_if.valid = 1'b0;
        @(negedge aclk);
        check("header_latency", {31'd0, m_if.valid}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || m_if.valid) && t < 200) begin
            @(negedge aclk);
            #1;
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("rst_m_valid", {31'd0, m_if.valid}, 32'd0);
        check("rst_m_data", m_if.data, 32'd0);
        check("rst_m_last", {31'd0, m_if.last}, 32'd0);
        check("rst_s_ready", {31'd0, s_if.ready}, 32'd1);

        // All-zero block
`ifdef PACKER_ZERO_SKIP_EN
        push(32'h0000_0000, 1'b1);
`else
        push(32'h0040_5555, 1'b0);
        push(32'h0000_0000, 1'b0);
        push(32'h0000_0000, 1'b1);
`endif
        send('0);
        drain();

        // Mixed widths: 8, 16, 32 then zeros
`ifdef PACKER_ZERO_SKIP_EN
        push(32'h0038_0039, 1'b0);
        push(32'hDE34_5612, 1'b0);
        push(32'h0078_9ABC, 1'b1);
`else
        push(32'h0060_5579, 1'b0);
        push(32'hDE34_5612, 1'b0);
        push(32'h0078_9ABC, 1'b0);
        push(32'h0000_0000, 1'b1);
`endif
        send(blk8(32'h12, 32'h3456, 32'h789A_BCDE, 0, 0, 0, 0, 0));
        drain();

        // Full 256-bit block
        push(32'h0100_FFFF, 1'b0);
        for (int i = 0; i < 8; i++) push(32'hFFFF_FFFF, i == 7);
        send({8{32'hFFFF_FFFF}});
        drain();

        // Four-word block under alternating back-pressure
        rdy_mode = 1;
        push(32'h0080_AAAA, 1'b0);
        push(32'h0202_0101, 1'b0);
        push(32'h0404_0303, 1'b0);
        push(32'h0606_0505, 1'b0);
        push(32'h0808_0707, 1'b1);
        send(blk8(32'h0101, 32'h0202, 32'h0303, 32'h0404,
                  32'h0505, 32'h0606, 32'h0707, 32'h0808));
        drain();
        rdy_mode = 0;

        // Reset after the second payload word of an eight-word block
        base = mon_words;
        push(32'h0100_FFFF, 1'b0);
        for (int i = 0; i < 8; i++) push(32'hFFFF_FFFF, i == 7);
        send({8{32'hFFFF_FFFF}});
        t = 0;
        while (mon_words < base + 3 && t < 100) begin
            @(negedge aclk);
            #1;
            t++;
        end
        check("words_before_reset", 32'(mon_words - base), 32'd3);
        rdy_mode = 2;
        @(posedge aclk);
        #1 areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("reset_m_valid", {31'd0, m_if.valid}, 32'd0);
        sb.delete();
        @(posedge aclk);
        #1 areset = 1'b0;
        rdy_mode = 0;
        @(negedge aclk);
        check("post_reset_s_ready", {31'd0, s_if.ready}, 32'd1);
        check("post_reset_m_valid", {31'd0, m_if.valid}, 32'd0);

`ifdef PACKER_ZERO_SKIP_EN
        push(32'h0038_0039, 1'b0);
        push(32'hDE34_5612, 1'b0);
        push(32'h0078_9ABC, 1'b1);
`else
        push(32'h0060_5579, 1'b0);
        push(32'hDE34_5612, 1'b0);
        push(32'h0078_9ABC, 1'b0);
        push(32'h0000_0000, 1'b1);
`endif
        send(blk8(32'h12, 32'h3456, 32'h789A_BCDE, 0, 0, 0, 0, 0));
        drain();

        repeat (3) @(negedge aclk);
        check("idle_m_valid", {31'd0, m_if.valid}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
